imem_loader: RTL

- Boot-time writer for the instruction memory.
- Receives a byte stream over a valid/ready interface: a 4-byte little-endian word count N, followed by 4*N payload bytes.
- Assembles each group of 4 payload bytes into a little-endian 32-bit word and issues one write per word to the instruction memory write port, at consecutive word addresses from BASE_ADDR.
- Holds the core in reset while a load is in progress.

---
 rtl/imem_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed byte stream and
// writes it as little-endian 32-bit words from BASE_ADDR, holding the core in reset meanwhile.
module imem_loader #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          MAX_WORDS = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_byte_data,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_err
);

  // state   | meaning
  // IDLE    | waiting for i_start
  // LEN     | receiving the 4-byte word count N
  // DATA    | receiving the 4 bytes of the current word
  // WRITE   | one-cycle write strobe for the assembled word
  // DONE    | one-cycle completion pulse
  // ERR     | N exceeded MAX_WORDS; waits for a new i_start
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic              ready;
  logic              fire;
  logic [31:0]       len_full;
  logic [ADDR_W-1:0] addr_now;

  assign ready    = (state_q == S_LEN) || (state_q == S_DATA);
  assign fire     = i_byte_valid && ready;
  assign len_full = {i_byte_data, len_q[23:0]};
  assign addr_now = BASE_ADDR + ADDR_W'({word_cnt_q, 2'b00});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      word_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (i_start) begin
          state_d    = S_LEN;
          byte_cnt_d = '0;
          word_cnt_d = '0;
        end
      end
      S_LEN: begin
        if (fire) begin
          len_d[{byte_cnt_q, 3'b000} +: 8] = i_byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Decide on the full count including the byte arriving now.
            if (len_full == 32'd0)                 state_d = S_DONE;
            else if (len_full > 32'(MAX_WORDS))    state_d = S_ERR;
            else                                   state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = i_byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_addr_d  = addr_now;
        wr_data_d  = word_q;
        word_cnt_d = word_cnt_q + 32'd1;
        state_d    = (word_cnt_d == len_q) ? S_DONE : S_DATA;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_byte_ready = ready;
  assign o_wr_en      = (state_q == S_WRITE);
  assign o_wr_addr    = o_wr_en ? addr_now : wr_addr_q;
  assign o_wr_data    = o_wr_en ? word_q   : wr_data_q;
  assign o_busy       = ready || o_wr_en;
  assign o_cpu_rst    = o_busy;
  assign o_done       = (state_q == S_DONE);
  assign o_err        = (state_q == S_ERR);

endmodule
